// File: rtl/fifo_rd_drain.sv
// Read-side engine of the async FIFO: owns the read pointers and the empty flag, and
// issues paced memory reads that are presented on a valid/ready output stream.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 8,
  parameter int READ_IDLE  = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  drain_en,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  r_en,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [15:0]           rd_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, GAP} state_e;

  localparam logic [3:0] GAP_LAST = 4'((READ_IDLE > 0) ? READ_IDLE - 1 : 0);

  state_e                  state_q, state_d;
  logic [PTR_WIDTH:0]      b_rptr_q, b_rptr_d;
  logic [PTR_WIDTH:0]      g_rptr_q, g_rptr_d;
  logic                    empty_q, empty_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic [15:0]             rd_count_q, rd_count_d;
  logic [3:0]              gap_q, gap_d;
  logic                    slot_free;
  logic                    handshake;
  logic                    load;

  assign r_en      = (state_q == ISSUE);
  assign slot_free = ~m_valid_q | m_ready;
  assign handshake = m_valid_q & m_ready;

  // empty is judged against the post-increment pointer, so a late write is seen next cycle
  always_comb begin
    b_rptr_d = b_rptr_q + {{PTR_WIDTH{1'b0}}, (r_en & ~empty_q)};
    g_rptr_d = (b_rptr_d >> 1) ^ b_rptr_d;
    empty_d  = (g_rptr_d == g_wptr_sync);
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (drain_en && !empty_q && slot_free) state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // memory holds data_out until the next r_en, so waiting here loses nothing
        if (slot_free) begin
          load    = 1'b1;
          gap_d   = '0;
          state_d = (READ_IDLE > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d  = load | (m_valid_q & ~m_ready);
    m_data_d   = load ? mem_data : m_data_q;
    rd_count_d = rd_count_q + 16'(handshake);
  end

  always_ff @(posedge rclk) begin
    if (rrst_n) begin
      state_q    <= IDLE;
      b_rptr_q   <= '0;
      g_rptr_q   <= '0;
      empty_q    <= 1'b1;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      rd_count_q <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      b_rptr_q   <= b_rptr_d;
      g_rptr_q   <= g_rptr_d;
      empty_q    <= empty_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      rd_count_q <= rd_count_d;
      gap_q      <= gap_d;
    end
  end

  assign b_rptr   = b_rptr_q;
  assign g_rptr   = g_rptr_q;
  assign empty    = empty_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign rd_count = rd_count_q;

endmodule
